scnn_accum_pipe: RTL and testbench
==================================

Name: scnn_accum_pipe

Overview:
Parametrised, pipelined successor to the single-cycle 4-buffer partial-sum adder in the SCNN output stage. It sums NUM_BUF partial-sum buffers entry-wise, LANES entries per cycle. Results accumulate across successive buffer sets, e.g. input-channel groups, in an internal ACC_W-bit accumulator bank. The final result is presented with a valid/ready handshake toward the PPU/output-activation writer.

Parameters:
NUM_BUF, 4, number of partial-sum buffers summed per set
NUM_ENT, 64, entries per buffer
DW, 32, input entry width (signed two's complement)
ACC_W, 32, accumulator/output entry width, ACC_W >= DW
LANES, 16, entries processed per cycle; NUM_ENT % LANES == 0 or elaboration error
SAT_EN, 0, 1 = signed saturation, 0 = wrap-around

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  buffer set presented; must be held with stable data until accepted
in_ready  output  1  set accepted when in_valid & in_ready
in_first  input  1  qualified by in_valid; discard accumulator contents before this set
in_last  input  1  qualified by in_valid; final set, publish result
buffers  input  NUM_BUF*NUM_ENT*DW  packed [NUM_BUF-1:0][NUM_ENT-1:0][DW-1:0]
out_valid  output  1  accumulated result available
out_ready  input  1  consumer takes result
out_data  output  NUM_ENT*ACC_W  packed [NUM_ENT-1:0][ACC_W-1:0], accumulator bank
ovf_flag  output  1  sticky; saturation/wrap occurred since last in_first set
busy  output  1  state != IDLE

Behaviour:
- P = NUM_ENT/LANES passes per set. FSM states: IDLE, RUN, DONE.
- Reset, async: state IDLE, pass counter 0, accumulator bank 0, out_valid 0, in_ready 0, ovf_flag 0, busy 0. Reset mid-RUN or mid-DONE abandons the set with no partial output.
- IDLE: if in_valid, go to RUN next cycle with pass p=0.
- RUN: each cycle, lane i updates entry e = p*LANES+i:
  - acc[e] <= (in_first ? 0 : acc[e]) + sum over buffers of sext(buffers[b][e]).
  - p increments each cycle.
  - in_ready is combinationally 1 only when p == P-1, so acceptance coincides with the last pass.
  - At acceptance: in_last -> DONE; otherwise -> IDLE.
  - Throughput is one set per P+1 cycles.
- DONE: out_valid = 1 and out_data holds stable. in_ready stays 0, and new in_valid waits. When out_ready is sampled high, go to IDLE and clear out_valid. The accumulator is not cleared; the next set must carry in_first.
- Latency: in_valid rises in cycle 0; acceptance in cycle P; out_valid in cycle P+1.
- in_valid dropping during RUN is a protocol violation. The bench asserts on it; the RTL returns to IDLE and leaves already-updated entries as is.
- Arithmetic:
  - Per-lane exact sum in ACC_W+$clog2(NUM_BUF)+1 bits, inputs sign-extended.
  - SAT_EN=1: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - SAT_EN=0: truncate to ACC_W.
  - Either way, any lane out of range sets ovf_flag.
  - ovf_flag clears on the first pass of an in_first set.
- out_data is visible in all states, but is only meaningful while out_valid is high.

Decomposition:
- Package scnn_accum_pkg holds:
  - state_t enum {IDLE, RUN, DONE}.
  - Function sat_clamp(value, width).
  - Localparam helpers for SUM_W and P.
- Sub-module scnn_lane_adder is combinational: NUM_BUF sign-extended inputs plus accumulator in, with a first/clear select. It outputs the new value and an overflow bit, and is instantiated LANES times.
- FSM, pass counter, accumulator bank and handshake live in scnn_accum_pipe.

Test Plan:
- Defaults, one set with first=last=1, buffers[b][w]=w+b -> accept in cycle 4, out_valid in cycle 5, out_data[w]=4w+6, ovf_flag=0.
- Three sets (first / - / last), every entry = 1 -> in_ready pulses 3 times, out_data all 12, exactly one out_valid.
- Entries -5, 2, 0, -1 -> out_data = -4 (0xFFFFFFFC); DW=16, ACC_W=32 -> sign extension correct.
- SAT_EN=1, entries 0x7FFFFFF0, 0x20, 0, 0 -> 0x7FFFFFFF with ovf_flag=1. Same with SAT_EN=0 -> 0x80000010, ovf_flag=1. Next in_first set clears the flag.
- out_ready low 10 cycles in DONE with next set pending -> in_ready stays 0 and out_data stable; after the handshake, next set runs normally.
- Reset asserted at pass 2 of an accumulating set -> all outputs 0 immediately. Then a fresh first/last set of 1s -> out_data all 4, no stale contribution.

Source files
------------

// File: rtl/scnn_accum_pkg.sv
// Shared types and arithmetic helpers for the SCNN partial-sum accumulator pipeline.
package scnn_accum_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Working width for range checks; must cover the widest per-lane exact sum.
    localparam int MAX_W = 128;

    function automatic int sum_w(input int acc_w, input int num_buf);
        return acc_w + $clog2(num_buf) + 1;
    endfunction

    function automatic int num_pass(input int num_ent, input int lanes);
        return num_ent / lanes;
    endfunction

    function automatic logic signed [MAX_W-1:0] range_max(input int width);
        logic signed [MAX_W-1:0] v;
        v = MAX_W'(1) <<< (width - 1);
        return v - MAX_W'(1);
    endfunction

    function automatic logic out_of_range(input logic signed [MAX_W-1:0] value, input int width);
        logic signed [MAX_W-1:0] hi;
        hi = range_max(width);
        return (value > hi) || (value < (-hi - MAX_W'(1)));
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_clamp(input logic signed [MAX_W-1:0] value,
                                                          input int width);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = range_max(width);
        lo = -hi - MAX_W'(1);
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/scnn_accum_if.sv
// Buffer-set input and accumulated-result output handshake of the accumulator pipeline.
interface scnn_accum_if #(
    parameter int NUM_BUF = 4,
    parameter int NUM_ENT = 64,
    parameter int DW      = 32,
    parameter int ACC_W   = 32
);
    logic                                     in_valid;
    logic                                     in_ready;
    logic                                     in_first;
    logic                                     in_last;
    logic [NUM_BUF-1:0][NUM_ENT-1:0][DW-1:0]  buffers;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [NUM_ENT-1:0][ACC_W-1:0]            out_data;
    logic                                     ovf_flag;
    logic                                     busy;

    modport master (
        output in_valid, in_first, in_last, buffers, out_ready,
        input  in_ready, out_valid, out_data, ovf_flag, busy
    );

    modport slave (
        input  in_valid, in_first, in_last, buffers, out_ready,
        output in_ready, out_valid, out_data, ovf_flag, busy
    );
endinterface

// File: rtl/scnn_lane_adder.sv
// One lane: sums NUM_BUF sign-extended entries onto the (optionally cleared) accumulator,
// then saturates or wraps to ACC_W and reports whether the exact sum left that range.
module scnn_lane_adder
    import scnn_accum_pkg::*;
#(
    parameter int NUM_BUF = 4,
    parameter int DW      = 32,
    parameter int ACC_W   = 32,
    parameter int SAT_EN  = 0
) (
    input  logic [NUM_BUF-1:0][DW-1:0] i_ent,
    input  logic [ACC_W-1:0]           i_acc,
    input  logic                       i_clear,
    output logic [ACC_W-1:0]           o_sum,
    output logic                       o_ovf
);
    localparam int SUM_W = sum_w(ACC_W, NUM_BUF);

    logic signed [SUM_W-1:0] w_exact;
    logic signed [MAX_W-1:0] w_wide;

    // NOTE: w_exact gets a value before the loop on every pass, so no latch is inferred.
    always_comb begin
        w_exact = i_clear ? '0 : {{(SUM_W-ACC_W){i_acc[ACC_W-1]}}, i_acc};
        for (int b = 0; b < NUM_BUF; b++) begin
            w_exact = w_exact + {{(SUM_W-DW){i_ent[b][DW-1]}}, i_ent[b]};
        end
    end

    assign w_wide = {{(MAX_W-SUM_W){w_exact[SUM_W-1]}}, w_exact};
    assign o_ovf  = out_of_range(w_wide, ACC_W);

    if (SAT_EN != 0) begin : g_sat
        assign o_sum = ACC_W'(sat_clamp(w_wide, ACC_W));
    end else begin : g_wrap
        assign o_sum = w_exact[ACC_W-1:0];
    end
endmodule

// File: rtl/scnn_accum_pipe.sv
// Pipelined multi-buffer partial-sum accumulator: LANES entries per pass, NUM_ENT/LANES passes
// per buffer set, results accumulated across sets and published on the last one.
module scnn_accum_pipe
    import scnn_accum_pkg::*;
#(
    parameter int NUM_BUF = 4,
    parameter int NUM_ENT = 64,
    parameter int DW      = 32,
    parameter int ACC_W   = 32,
    parameter int LANES   = 16,
    parameter int SAT_EN  = 0
) (
    input logic         clk,
    input logic         reset,
    scnn_accum_if.slave bus
);
    localparam int P     = num_pass(NUM_ENT, LANES);
    localparam int PW    = (P > 1) ? $clog2(P) : 1;
    localparam int SUM_W = sum_w(ACC_W, NUM_BUF);

    if (NUM_ENT % LANES != 0) begin : g_bad_lanes
        $error("NUM_ENT must be a multiple of LANES");
    end
    if (ACC_W < DW || SUM_W >= MAX_W) begin : g_bad_width
        $error("ACC_W must be >= DW and the exact lane sum must fit MAX_W");
    end

    state_t                                 r_state;
    state_t                                 w_next;
    logic [PW-1:0]                          r_pass;
    logic [P-1:0][LANES-1:0][ACC_W-1:0]     r_acc;
    logic                                   r_ovf;
    logic                                   w_update;
    logic                                   w_last_pass;
    logic [NUM_BUF-1:0][P-1:0][LANES-1:0][DW-1:0] w_buf_view;
    logic [LANES-1:0][ACC_W-1:0]            w_lane_sum;
    logic [LANES-1:0]                       w_lane_ovf;

    // Entry e = p*LANES + i, so viewing the flat banks as [pass][lane] selects a whole pass at once.
    assign w_buf_view  = bus.buffers;
    assign w_last_pass = (r_pass == PW'(P - 1));

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [NUM_BUF-1:0][DW-1:0] w_ent;
        for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
            assign w_ent[b] = w_buf_view[b][r_pass][i];
        end
        scnn_lane_adder #(.NUM_BUF(NUM_BUF), .DW(DW), .ACC_W(ACC_W), .SAT_EN(SAT_EN)) u_adder (
            .i_ent   (w_ent),
            .i_acc   (r_acc[r_pass][i]),
            .i_clear (bus.in_first),
            .o_sum   (w_lane_sum[i]),
            .o_ovf   (w_lane_ovf[i])
        );
    end

    always_comb begin
        w_next   = r_state;
        w_update = 1'b0;
        case (r_state)
            IDLE: if (bus.in_valid) w_next = RUN;
            RUN: begin
                // A dropped in_valid abandons the set; entries already written stay as they are.
                if (!bus.in_valid) begin
                    w_next = IDLE;
                end else begin
                    w_update = 1'b1;
                    if (w_last_pass) w_next = bus.in_last ? DONE : IDLE;
                end
            end
            DONE: if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: the accumulator bank is reset too, so an aborted set never leaks into out_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_pass  <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state <= w_next;
            if (w_update) begin
                r_acc[r_pass] <= w_lane_sum;
                r_pass        <= w_last_pass ? '0 : r_pass + 1'b1;
                r_ovf         <= ((bus.in_first && r_pass == '0) ? 1'b0 : r_ovf) | (|w_lane_ovf);
            end else begin
                r_pass <= '0;
            end
        end
    end

    assign bus.in_ready  = (r_state == RUN) && w_last_pass;
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_data  = r_acc;
    assign bus.ovf_flag  = r_ovf;
endmodule

// File: tb/tb_scnn_accum_pipe.sv
// Self-checking bench for scnn_accum_pipe: default wrap instance plus small saturating and
// 16-bit-input instances, table vectors, hand-written corner sequences and a random model run.
module tb_scnn_accum_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scnn_accum_if #(.NUM_BUF(4), .NUM_ENT(64), .DW(32), .ACC_W(32)) if_a ();
    scnn_accum_if #(.NUM_BUF(4), .NUM_ENT(8),  .DW(16), .ACC_W(32)) if_b ();
    scnn_accum_if #(.NUM_BUF(4), .NUM_ENT(8),  .DW(32), .ACC_W(32)) if_c ();

    scnn_accum_pipe #(.NUM_BUF(4), .NUM_ENT(64), .DW(32), .ACC_W(32), .LANES(16), .SAT_EN(0))
        u_a (.clk(clk), .reset(reset), .bus(if_a));
    scnn_accum_pipe #(.NUM_BUF(4), .NUM_ENT(8), .DW(16), .ACC_W(32), .LANES(4), .SAT_EN(0))
        u_b (.clk(clk), .reset(reset), .bus(if_b));
    scnn_accum_pipe #(.NUM_BUF(4), .NUM_ENT(8), .DW(32), .ACC_W(32), .LANES(4), .SAT_EN(1))
        u_c (.clk(clk), .reset(reset), .bus(if_c));

    // The two small instances share one control stream.
    logic s_valid, s_first, s_last, s_ready;
    assign if_b.in_valid  = s_valid;
    assign if_b.in_first  = s_first;
    assign if_b.in_last   = s_last;
    assign if_b.out_ready = s_ready;
    assign if_c.in_valid  = s_valid;
    assign if_c.in_first  = s_first;
    assign if_c.in_last   = s_last;
    assign if_c.out_ready = s_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_a [64];
    int          m_acc [64];
    bit          m_ovf;

    typedef struct packed {
        logic [3:0][31:0] c;
        logic [31:0]      exp_c;
        logic             ovf_c;
        logic [3:0][15:0] b;
        logic [31:0]      exp_b;
    } vec_t;
    vec_t tbl [5];

    // Monitors: in_ready cycles and out_valid rising edges on the default instance.
    int   rdy_pulses = 0;
    int   ov_rises   = 0;
    logic prev_ov    = 1'b0;
    always @(negedge clk) begin
        if (if_a.in_ready) rdy_pulses++;
        if (if_a.out_valid && !prev_ov) ov_rises++;
        prev_ov = if_a.out_valid;
    end

    // in_valid must be held for the whole RUN phase.
    always @(posedge clk) begin
        if (!reset && if_a.busy && !if_a.out_valid)
            assert (if_a.in_valid) else $error("in_valid dropped while instance a was running");
        if (!reset && if_c.busy && !if_c.out_valid)
            assert (s_valid) else $error("in_valid dropped while small instances were running");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_bank_a(input string name);
        int bad;
        bad = -1;
        for (int e = 0; e < 64; e++)
            if (bad < 0 && if_a.out_data[e] !== exp_a[e]) bad = e;
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL %s: entry %0d got 0x%08h expected 0x%08h", name, bad,
                     if_a.out_data[bad], exp_a[bad]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_a(input int b0, input int b1, input int b2, input int b3);
        for (int e = 0; e < 64; e++) begin
            if_a.buffers[0][e] = b0;
            if_a.buffers[1][e] = b1;
            if_a.buffers[2][e] = b2;
            if_a.buffers[3][e] = b3;
        end
    endtask

    task automatic send_a(input bit first, input bit last);
        int n;
        if_a.in_first = first;
        if_a.in_last  = last;
        if_a.in_valid = 1'b1;
        n = 0;
        while (!if_a.in_ready && n < 40) begin
            step();
            n++;
        end
        check("a_accept", if_a.in_ready, 1);
        step();
        if_a.in_valid = 1'b0;
        if_a.in_first = 1'b0;
        if_a.in_last  = 1'b0;
    endtask

    task automatic wait_out_a();
        int n;
        n = 0;
        while (!if_a.out_valid && n < 40) begin
            step();
            n++;
        end
        check("a_out_valid", if_a.out_valid, 1);
    endtask

    task automatic release_a();
        if_a.out_ready = 1'b1;
        step();
        if_a.out_ready = 1'b0;
    endtask

    task automatic run_small();
        int n;
        s_first = 1'b1;
        s_last  = 1'b1;
        s_valid = 1'b1;
        n = 0;
        while (!if_c.in_ready && n < 40) begin
            step();
            n++;
        end
        check("small_accept", {if_b.in_ready, if_c.in_ready}, 2'b11);
        step();
        s_valid = 1'b0;
        check("small_out_valid", {if_b.out_valid, if_c.out_valid}, 2'b11);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rdy, base_ov, nsets;
        reset = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_first = 1'b0; if_a.in_last = 1'b0;
        if_a.out_ready = 1'b0; if_a.buffers = '0;
        s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0; s_ready = 1'b0;
        if_b.buffers = '0; if_c.buffers = '0;

        tbl[0].c = {32'h0, 32'h0, 32'h20, 32'h7FFFFFF0};           tbl[0].exp_c = 32'h7FFFFFFF; tbl[0].ovf_c = 1'b1;
        tbl[0].b = {16'hFFFF, 16'h0000, 16'h0002, 16'hFFFB};        tbl[0].exp_b = 32'hFFFFFFFC;
        tbl[1].c = {32'd4, 32'd3, 32'd2, 32'd1};                    tbl[1].exp_c = 32'd10;       tbl[1].ovf_c = 1'b0;
        tbl[1].b = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};        tbl[1].exp_b = 32'h0001FFFC;
        tbl[2].c = {32'h0, 32'h0, 32'hFFFFFFFF, 32'h80000000};      tbl[2].exp_c = 32'h80000000; tbl[2].ovf_c = 1'b1;
        tbl[2].b = {16'h8000, 16'h8000, 16'h8000, 16'h8000};        tbl[2].exp_b = 32'hFFFE0000;
        tbl[3].c = {32'hFFFFFFFF, 32'h0, 32'h2, 32'hFFFFFFFB};      tbl[3].exp_c = 32'hFFFFFFFC; tbl[3].ovf_c = 1'b0;
        tbl[3].b = {16'hFE70, 16'h012C, 16'hFF38, 16'h0064};        tbl[3].exp_b = 32'hFFFFFF38;
        tbl[4].c = {32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
        tbl[4].exp_c = 32'h7FFFFFFF; tbl[4].ovf_c = 1'b1;
        tbl[4].b = '0;                                              tbl[4].exp_b = 32'h0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  if_a.in_ready, 0);
        check("rst_out_valid", if_a.out_valid, 0);
        check("rst_busy",      if_a.busy, 0);
        check("rst_ovf",       if_a.ovf_flag, 0);
        check("rst_out_data",  |if_a.out_data, 0);
        reset = 1'b0;
        step();

        // Latency: in_valid in cycle 0, acceptance in cycle 4, out_valid in cycle 5.
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 64; w++) if_a.buffers[b][w] = w + b;
        if_a.in_first = 1'b1; if_a.in_last = 1'b1; if_a.in_valid = 1'b1;
        check("lat_ready_c0", if_a.in_ready, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) begin
                if_a.in_valid = 1'b0; if_a.in_first = 1'b0; if_a.in_last = 1'b0;
            end
            check($sformatf("lat_ready_c%0d", k), if_a.in_ready, (k == 4));
            check($sformatf("lat_valid_c%0d", k), if_a.out_valid, (k == 5));
        end
        for (int w = 0; w < 64; w++) exp_a[w] = 4 * w + 6;
        cmp_bank_a("lat_data");
        check("lat_ovf", if_a.ovf_flag, 0);
        release_a();
        check("lat_idle_after", {if_a.busy, if_a.out_valid}, 2'b00);

        // Three accumulating sets of ones.
        fill_a(1, 1, 1, 1);
        base_rdy = rdy_pulses;
        base_ov  = ov_rises;
        send_a(1, 0);
        send_a(0, 0);
        send_a(0, 1);
        step(); step();
        for (int w = 0; w < 64; w++) exp_a[w] = 12;
        cmp_bank_a("three_sets_data");
        check("three_sets_ovf", if_a.ovf_flag, 0);
        release_a();
        step();
        check("three_sets_ready_pulses", rdy_pulses - base_rdy, 3);
        check("three_sets_valid_rises", ov_rises - base_ov, 1);

        // Wrap-around overflow, then a fresh in_first set clears the flag.
        fill_a(32'h7FFFFFF0, 32'h20, 0, 0);
        send_a(1, 1);
        wait_out_a();
        for (int w = 0; w < 64; w++) exp_a[w] = 32'h80000010;
        cmp_bank_a("wrap_data");
        check("wrap_ovf", if_a.ovf_flag, 1);
        release_a();
        fill_a(1, 1, 1, 1);
        send_a(1, 1);
        wait_out_a();
        for (int w = 0; w < 64; w++) exp_a[w] = 4;
        cmp_bank_a("wrap_clear_data");
        check("wrap_clear_ovf", if_a.ovf_flag, 0);
        release_a();

        // Backpressure in DONE with the next set already pending.
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 64; w++) if_a.buffers[b][w] = w * b + 1;
        send_a(1, 1);
        for (int w = 0; w < 64; w++) exp_a[w] = 6 * w + 4;
        fill_a(1, 1, 1, 1);
        if_a.in_first = 1'b1; if_a.in_last = 1'b1; if_a.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_ready_%0d", k), {if_a.in_ready, if_a.out_valid}, 2'b01);
            cmp_bank_a($sformatf("bp_data_%0d", k));
            step();
        end
        release_a();
        send_a(1, 1);
        wait_out_a();
        for (int w = 0; w < 64; w++) exp_a[w] = 4;
        cmp_bank_a("bp_next_data");
        release_a();

        // Reset at pass 2 of an accumulating set.
        fill_a(1, 1, 1, 1);
        send_a(1, 0);
        if_a.in_first = 1'b0; if_a.in_last = 1'b1; if_a.in_valid = 1'b1;
        step(); step(); step();
        check("mid_reset_busy_before", if_a.busy, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_data", |if_a.out_data, 0);
        check("mid_reset_flags", {if_a.out_valid, if_a.busy, if_a.in_ready, if_a.ovf_flag}, 4'b0000);
        if_a.in_valid = 1'b0; if_a.in_last = 1'b0;
        step();
        reset = 1'b0;
        step();
        send_a(1, 1);
        wait_out_a();
        for (int w = 0; w < 64; w++) exp_a[w] = 4;
        cmp_bank_a("after_reset_data");
        release_a();

        // Table vectors on the saturating and 16-bit-input instances.
        for (int t = 0; t < 5; t++) begin
            for (int e = 0; e < 8; e++)
                for (int k = 0; k < 4; k++) begin
                    if_c.buffers[k][e] = tbl[t].c[k];
                    if_b.buffers[k][e] = tbl[t].b[k];
                end
            run_small();
            for (int e = 0; e < 8; e++) begin
                check($sformatf("vec%0d_sat_e%0d", t, e), if_c.out_data[e], tbl[t].exp_c);
                check($sformatf("vec%0d_sext_e%0d", t, e), if_b.out_data[e], tbl[t].exp_b);
            end
            check($sformatf("vec%0d_sat_ovf", t), if_c.ovf_flag, tbl[t].ovf_c);
            check($sformatf("vec%0d_sext_ovf", t), if_b.ovf_flag, 0);
            s_ready = 1'b1;
            step();
            s_ready = 1'b0;
        end

        // Random set sequences against a plain-arithmetic model of the bank.
        for (int it = 0; it < 25; it++) begin
            nsets = $urandom_range(1, 3);
            for (int s = 0; s < nsets; s++) begin
                int mode;
                bit set_ovf;
                mode = $urandom_range(0, 2);
                set_ovf = 1'b0;
                for (int e = 0; e < 64; e++) begin
                    longint sum;
                    sum = (s == 0) ? 0 : longint'(m_acc[e]);
                    for (int b = 0; b < 4; b++) begin
                        int v;
                        if (mode == 0) v = int'($urandom);
                        else if (mode == 1) v = int'($urandom_range(0, 200)) - 100;
                        else v = 32'h20000000 + int'($urandom_range(0, 4095));
                        if_a.buffers[b][e] = v;
                        sum += longint'(v);
                    end
                    if (sum > 64'sd2147483647 || sum < -64'sd2147483648) set_ovf = 1'b1;
                    m_acc[e] = int'(sum);
                end
                m_ovf = ((s == 0) ? 1'b0 : m_ovf) | set_ovf;
                send_a(s == 0, s == nsets - 1);
            end
            wait_out_a();
            repeat ($urandom_range(0, 3)) step();
            for (int e = 0; e < 64; e++) exp_a[e] = m_acc[e];
            cmp_bank_a($sformatf("rand%0d_data", it));
            check($sformatf("rand%0d_ovf", it), if_a.ovf_flag, m_ovf);
            release_a();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
